// File: rtl/timer_pkg.sv
// Shared register map, control bit positions and helpers for the multi-channel
// millisecond timer on the 8-bit Wishbone bus.
package timer_pkg;

  localparam int unsigned CHAN_STRIDE = 8;

  // Byte offsets inside the global block and inside each channel block
  localparam logic [2:0] OFF_VAL0    = 3'd0;
  localparam logic [2:0] OFF_VAL1    = 3'd1;
  localparam logic [2:0] OFF_VAL2    = 3'd2;
  localparam logic [2:0] OFF_VAL3    = 3'd3;
  localparam logic [2:0] OFF_CTRL    = 3'd4;
  localparam logic [2:0] OFF_STATUS  = 3'd5;
  localparam logic [2:0] OFF_PENDVEC = 3'd4;

  localparam int unsigned CTRL_ARMED     = 0;
  localparam int unsigned CTRL_PERIODIC  = 1;
  localparam int unsigned CTRL_IRQEN     = 2;
  localparam int unsigned STATUS_PENDING = 0;

  // A decoded register write aimed at one channel
  typedef struct packed {
    logic       en;
    logic [2:0] off;
    logic [7:0] dat;
  } reg_wr_t;

  function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] idx);
    return word[8*idx +: 8];
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One compare channel: value shadow, target/period, control bits, pending flag
// and the per-cycle match against the shared millisecond counter.
module timer_channel
  import timer_pkg::*;
(
  input  logic        I_wb_clk,
  input  logic        I_reset,
  input  logic [31:0] ms,
  input  reg_wr_t     wr,
  input  logic [2:0]  rd_off,
  output logic [7:0]  rd_dat,
  output logic        pending,
  output logic        irq
);

  logic [23:0] shadow;
  logic [31:0] target;
  logic [31:0] period;
  logic        armed;
  logic        periodic;
  logic        irqen;

  logic        commit;
  logic        clear;
  logic        match;
  logic [31:0] value;

  assign commit = wr.en && (wr.off == OFF_VAL3);
  assign clear  = wr.en && (wr.off == OFF_STATUS) && wr.dat[STATUS_PENDING];
  assign value  = {wr.dat, shadow};
  assign match  = armed && (ms == target);

  always_ff @(posedge I_wb_clk) begin
    if (I_reset) begin
      shadow   <= '0;
      target   <= '0;
      period   <= '0;
      armed    <= 1'b0;
      periodic <= 1'b0;
      irqen    <= 1'b0;
      pending  <= 1'b0;
    end else begin
      // NOTE: with <= the last assignment to a register in this block wins at
      // the edge, so statement order below is the priority order.
      if (commit) begin
        armed <= 1'b1;
        if (periodic) begin
          period <= value;
          target <= ms + value;
        end else begin
          target <= value;
        end
      end else if (match) begin
        if (periodic && (period != '0)) target <= target + period;
        else                            armed  <= 1'b0;
      end

      // A commit swallows a coincident match; a match beats a clear
      if (clear)            pending <= 1'b0;
      if (match && !commit) pending <= 1'b1;

      if (wr.en) begin
        case (wr.off)
          OFF_VAL0: shadow[7:0]   <= wr.dat;
          OFF_VAL1: shadow[15:8]  <= wr.dat;
          OFF_VAL2: shadow[23:16] <= wr.dat;
          OFF_CTRL: begin
            periodic <= wr.dat[CTRL_PERIODIC];
            irqen    <= wr.dat[CTRL_IRQEN];
            if (!wr.dat[CTRL_ARMED]) armed <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    // NOTE: default every output of a combinational block first so no path
    // leaves it unassigned and a latch cannot be inferred.
    rd_dat = '0;
    case (rd_off)
      OFF_VAL0, OFF_VAL1, OFF_VAL2, OFF_VAL3: rd_dat = byte_of(target, rd_off[1:0]);
      OFF_CTRL: begin
        rd_dat[CTRL_ARMED]    = armed;
        rd_dat[CTRL_PERIODIC] = periodic;
        rd_dat[CTRL_IRQEN]    = irqen;
      end
      OFF_STATUS: rd_dat[STATUS_PENDING] = pending;
      default: ;
    endcase
  end

  assign irq = pending & irqen;

endmodule

// File: rtl/timer_multi_wb8.sv
// Multi-channel millisecond timer on the 8-bit Wishbone bus: shared prescaler,
// 32-bit ms counter, CHANNELS compare channels. Optional TIMER_WRITABLE_TIME_EN.
module timer_multi_wb8
  import timer_pkg::*;
#(
  parameter int CLOCKFREQ = 25000000,
  parameter int CHANNELS  = 2,
  parameter int ADRWIDTH  = $clog2(CHAN_STRIDE * (CHANNELS + 1))
) (
  input  logic                I_wb_clk,
  input  logic                I_reset,
  input  logic [ADRWIDTH-1:0] I_wb_adr,
  input  logic [7:0]          I_wb_dat,
  input  logic                I_wb_stb,
  input  logic                I_wb_we,
  output logic                O_wb_ack,
  output logic [7:0]          O_wb_dat,
  output logic                O_interrupt
);

  localparam int TICKS = CLOCKFREQ / 1000;
  localparam int PW    = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam int BW    = ADRWIDTH - 3;

  logic [BW-1:0] blk;
  logic [2:0]    off;
  logic [PW-1:0] prescaler;
  logic          tick;
  logic [31:0]   ms;
  logic [23:0]   snapshot;
  logic          snap_load;
  logic [7:0]    rdata;

  logic [CHANNELS-1:0] pend;
  logic [CHANNELS-1:0] irq_vec;
  logic [7:0]          ch_rd [CHANNELS];

  assign blk       = I_wb_adr[ADRWIDTH-1:3];
  assign off       = I_wb_adr[2:0];
  assign tick      = (prescaler == PW'(TICKS - 1));
  assign snap_load = I_wb_stb && !I_wb_we && (blk == '0) && (off == OFF_VAL0);

`ifdef TIMER_WRITABLE_TIME_EN
  logic [23:0] time_shadow;
  logic        wr_glob;
  assign wr_glob = I_wb_stb && I_wb_we && (blk == '0);
`endif

  always_ff @(posedge I_wb_clk) begin
    if (I_reset) begin
      prescaler <= '0;
      ms        <= '0;
      snapshot  <= '0;
`ifdef TIMER_WRITABLE_TIME_EN
      time_shadow <= '0;
`endif
    end else begin
      if (tick) begin
        prescaler <= '0;
        ms        <= ms + 32'd1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
      // Upper bytes are frozen when byte 0 is read so a multi-byte read is coherent
      if (snap_load) snapshot <= ms[31:8];
`ifdef TIMER_WRITABLE_TIME_EN
      if (wr_glob) begin
        case (off)
          OFF_VAL0: time_shadow[7:0]   <= I_wb_dat;
          OFF_VAL1: time_shadow[15:8]  <= I_wb_dat;
          OFF_VAL2: time_shadow[23:16] <= I_wb_dat;
          OFF_VAL3: begin
            ms        <= {I_wb_dat, time_shadow};
            prescaler <= '0;
          end
          default: ;
        endcase
      end
`endif
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    reg_wr_t wr;
    assign wr = '{en:  I_wb_stb && I_wb_we && (blk == BW'(c + 1)),
                  off: off,
                  dat: I_wb_dat};

    timer_channel u_chan (
      .I_wb_clk (I_wb_clk),
      .I_reset  (I_reset),
      .ms       (ms),
      .wr       (wr),
      .rd_off   (off),
      .rd_dat   (ch_rd[c]),
      .pending  (pend[c]),
      .irq      (irq_vec[c])
    );
  end

  always_comb begin
    rdata = '0;
    if (blk == '0) begin
      case (off)
        OFF_VAL0:    rdata = ms[7:0];
        OFF_VAL1:    rdata = snapshot[7:0];
        OFF_VAL2:    rdata = snapshot[15:8];
        OFF_VAL3:    rdata = snapshot[23:16];
        OFF_PENDVEC: rdata[CHANNELS-1:0] = pend;
        default: ;
      endcase
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (blk == BW'(c + 1)) rdata = ch_rd[c];
      end
    end
  end

  always_ff @(posedge I_wb_clk) begin
    if (I_reset) begin
      O_wb_ack    <= 1'b0;
      O_wb_dat    <= '0;
      O_interrupt <= 1'b0;
    end else begin
      O_wb_ack    <= I_wb_stb;
      if (I_wb_stb) O_wb_dat <= rdata;
      O_interrupt <= |irq_vec;
    end
  end

endmodule

// File: tb/tb_timer_multi_wb8.sv
// Scoreboard bench for timer_multi_wb8 at 4 cycles/ms with two channels.
module tb_timer_multi_wb8;

  localparam int CLOCKFREQ = 4000;
  localparam int CHANNELS  = 2;
  localparam int AW        = 5;

  logic          I_wb_clk = 1'b0;
  logic          I_reset  = 1'b1;
  logic [AW-1:0] adr  = '0;
  logic [7:0]    wdat = '0;
  logic          stb  = 1'b0;
  logic          we   = 1'b0;
  logic          ack;
  logic [7:0]    rdat;
  logic          irq;

  timer_multi_wb8 #(.CLOCKFREQ(CLOCKFREQ), .CHANNELS(CHANNELS)) dut (
    .I_wb_clk    (I_wb_clk),
    .I_reset     (I_reset),
    .I_wb_adr    (adr),
    .I_wb_dat    (wdat),
    .I_wb_stb    (stb),
    .I_wb_we     (we),
    .O_wb_ack    (ack),
    .O_wb_dat    (rdat),
    .O_interrupt (irq)
  );

  always #5 I_wb_clk = ~I_wb_clk;

  // Clock edges since reset release; ms after n edges is n/4
  int n;
  always @(posedge I_wb_clk) begin
    if (I_reset) n <= 0;
    else         n <= n + 1;
  end

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    string      tag;
    logic [7:0] exp;
    bit         is_read;
  } sb_t;
  sb_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge I_wb_clk) begin
    sb_t e;
    if (ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_ack", 32'(ack), 32'd0);
      end else begin
        e = exp_q.pop_front();
        if (e.is_read) check(e.tag, 32'(rdat), 32'(e.exp));
      end
    end
  end

  task automatic bus(input logic [AW-1:0] a, input bit w, input logic [7:0] d,
                     input logic [7:0] e, input string tag);
    sb_t s;
    s.tag = tag; s.exp = e; s.is_read = !w;
    exp_q.push_back(s);
    adr = a; we = w; wdat = d; stb = 1'b1;
    @(negedge I_wb_clk);
    stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [7:0] d);
    bus(a, 1'b1, d, 8'h00, "write");
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [7:0] e, input string tag);
    bus(a, 1'b0, 8'h00, e, tag);
  endtask

  task automatic wait_n(input int k);
    int guard = 0;
    if (n > k) check("schedule", 32'(n), 32'(k));
    while (n < k && guard < 5000) begin
      @(negedge I_wb_clk);
      guard++;
    end
  endtask

  // Reset with a strobe held: the ack must be dropped and outputs cleared
  task automatic do_reset();
    I_reset = 1'b1; stb = 1'b1; we = 1'b0; adr = '0;
    @(negedge I_wb_clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_dat", 32'(rdat), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    stb = 1'b0;
    repeat (2) @(negedge I_wb_clk);
    I_reset = 1'b0;
  endtask

  initial begin
    do_reset();

    // Time read after 40 cycles, reserved and unmapped bytes
    wait_n(40);
    rd(5'd0, 8'd10, "ms_b0");
    rd(5'd1, 8'd0, "ms_b1");
    rd(5'd2, 8'd0, "ms_b2");
    rd(5'd3, 8'd0, "ms_b3");
    rd(5'd5, 8'd0, "glob_rsvd");
    rd(5'd14, 8'd0, "ch_rsvd");
    rd(5'd24, 8'd0, "unmapped");
`ifndef TIMER_WRITABLE_TIME_EN
    wr(5'd0, 8'h55);
    rd(5'd0, 8'(n / 4), "ms_ro");
`endif

    // One-shot on channel 0, target 5
    do_reset();
    wr(5'd12, 8'h04);
    wr(5'd8, 8'd5); wr(5'd9, 8'd0); wr(5'd10, 8'd0); wr(5'd11, 8'd0);
    wait_n(21);
    check("os_irq_early", 32'(irq), 32'd0);
    wait_n(22);
    check("os_irq", 32'(irq), 32'd1);
    rd(5'd12, 8'h04, "os_ctrl");
    rd(5'd13, 8'h01, "os_status");
    rd(5'd4, 8'h01, "os_pendvec");
    rd(5'd8, 8'd5, "os_target");
    wr(5'd13, 8'h01);
    check("os_irq_hold", 32'(irq), 32'd1);
    @(negedge I_wb_clk);
    check("os_irq_clr", 32'(irq), 32'd0);
    rd(5'd13, 8'h00, "os_status_clr");

    // Periodic on channel 1, committed at ms=2 with period 3
    do_reset();
    wait_n(6);
    wr(5'd20, 8'h06);
    wait_n(8);
    wr(5'd16, 8'd3); wr(5'd17, 8'd0); wr(5'd18, 8'd0); wr(5'd19, 8'd0);
    wait_n(14);
    rd(5'd16, 8'd5, "per_t0");
    wait_n(22);
    rd(5'd16, 8'd8, "per_t1");
    rd(5'd21, 8'h01, "per_st1");
    wr(5'd21, 8'h01);
    rd(5'd21, 8'h00, "per_clr1");
    wait_n(34);
    check("per_irq", 32'(irq), 32'd1);
    rd(5'd16, 8'd11, "per_t2");
    rd(5'd21, 8'h01, "per_st2");
    wr(5'd21, 8'h01);
    wait_n(46);
    rd(5'd16, 8'd14, "per_t3");
    rd(5'd21, 8'h01, "per_st3");
    rd(5'd4, 8'h02, "per_pendvec");
    rd(5'd20, 8'h07, "per_ctrl");

    // Match coinciding with a clear, then with a commit
    do_reset();
    wr(5'd12, 8'h02);
    wr(5'd8, 8'd2);
    wr(5'd11, 8'd0);
    wait_n(10);
    rd(5'd13, 8'h01, "sc_first");
    wait_n(16);
    wr(5'd13, 8'h01);
    rd(5'd13, 8'h01, "sc_setwins");
    wait_n(20);
    wr(5'd13, 8'h01);
    rd(5'd13, 8'h00, "sc_cleared");
    wait_n(22);
    wr(5'd8, 8'd10);
    wait_n(24);
    wr(5'd11, 8'd0);
    rd(5'd13, 8'h00, "sc_commitwins");
    rd(5'd8, 8'd16, "sc_target");
    rd(5'd12, 8'h03, "sc_ctrl");

    // Snapshot coherence across the 0xFF -> 0x100 rollover
    do_reset();
    wait_n(1023);
    rd(5'd0, 8'hFF, "snap_b0");
    rd(5'd1, 8'h00, "snap_b1");
    rd(5'd0, 8'h00, "snap_b0_next");
    rd(5'd1, 8'h01, "snap_b1_next");

`ifdef TIMER_WRITABLE_TIME_EN
    // Wrap: time 0xFFFFFFFE, periodic period 3 -> match at ms=1, next target 4
    do_reset();
    wr(5'd12, 8'h02);
    wr(5'd8, 8'd3);
    wr(5'd0, 8'hFE); wr(5'd1, 8'hFF); wr(5'd2, 8'hFF); wr(5'd3, 8'hFF);
    wr(5'd11, 8'd0);
    rd(5'd0, 8'hFE, "wrap_time_b0");
    rd(5'd1, 8'hFF, "wrap_time_b1");
    wait_n(16);
    rd(5'd13, 8'h00, "wrap_pre");
    wait_n(20);
    rd(5'd13, 8'h01, "wrap_hit");
    rd(5'd8, 8'd4, "wrap_target");
    rd(5'd11, 8'd0, "wrap_target_b3");
`endif

    repeat (3) @(negedge I_wb_clk);
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
